// File: rtl/optical_bit_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : optical_bit_receiver_if
// Description : Signal bundle between the photodiode front end and the optical
//               bit receiver.
//                 rx_in       - comparator output toward the receiver (idle 0)
//                 data_out    - last correctly framed byte
//                 data_valid  - one-cycle pulse when data_out updates
//                 frame_error - one-cycle pulse on a bad stop bit
//                 busy        - receiver is inside a frame
//                 bit_tick    - one-cycle pulse at each data/stop sample point
//               master : drives rx_in, observes the receiver outputs
//               slave  : the receiver side
// Revision    : 1.0 - initial release
// ============================================================================
interface optical_bit_receiver_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;
    logic       bit_tick;

    modport master (
        output rx_in,
        input  data_out, data_valid, frame_error, busy, bit_tick
    );

    modport slave (
        input  rx_in,
        output data_out, data_valid, frame_error, busy, bit_tick
    );
endinterface
`default_nettype wire

// File: rtl/optical_bit_receiver.sv
`default_nettype none
// ============================================================================
// Module      : optical_bit_receiver
// Description : Receive-side deserializer for the optical link. Oversamples
//               the photodiode comparator output and recovers framed bytes:
//               start bit (1), 8 data bits LSB first, stop bit (0).
//               Ports:
//                 clock - system clock
//                 reset - synchronous, active-high
//                 bus   - optical_bit_receiver_if.slave (rx_in in; data_out,
//                         data_valid, frame_error, busy, bit_tick out)
//               Parameters:
//                 BIT_CYCLES - clocks per bit
//                 HALF_BIT   - clocks from start edge to start-bit centre
//                 RESYNC     - 1 = realign the bit counter on line transitions
// Revision    : 1.0 - initial release
// ============================================================================
module optical_bit_receiver #(
    parameter int BIT_CYCLES = 216,
    parameter int HALF_BIT   = 108,
    parameter bit RESYNC     = 1'b1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    optical_bit_receiver_if.slave bus
);

    localparam int                c_CW          = $clog2(BIT_CYCLES);
    localparam logic [c_CW-1:0]   c_BIT_LAST    = c_CW'(BIT_CYCLES - 1);
    localparam logic [c_CW-1:0]   c_HALF_LAST   = c_CW'(HALF_BIT - 1);
    // Loading this value on an edge places the next sample HALF_BIT clocks later.
    localparam logic [c_CW-1:0]   c_RESYNC_LOAD = c_CW'(BIT_CYCLES - HALF_BIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_count;
    logic [2:0]      r_index;
    logic [7:0]      r_shift;
    logic [7:0]      r_data_out;
    logic            r_data_valid;
    logic            r_frame_error;
    logic            r_bit_tick;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    logic            r_rx_meta;
    logic            r_rx_s;
    logic            r_rx_d;

    logic            w_rise;
    logic            w_resync_edge;

    assign w_rise = r_rx_s & ~r_rx_d;

    generate
        if (RESYNC) begin : g_resync
            assign w_resync_edge = r_rx_s ^ r_rx_d;
        end else begin : g_no_resync
            assign w_resync_edge = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta     <= 1'b0;
            r_rx_s        <= 1'b0;
            r_rx_d        <= 1'b0;
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_index       <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_bit_tick    <= 1'b0;
        end else begin
            r_rx_meta     <= bus.rx_in;
            r_rx_s        <= r_rx_meta;
            r_rx_d        <= r_rx_s;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_bit_tick    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Edge-triggered so a line stuck high never retriggers.
                    if (w_rise) begin
                        r_state <= S_START;
                        r_count <= '0;
                    end
                end

                S_START: begin
                    if (!r_rx_s) begin
                        // Start bit too short: treat as a glitch.
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end else if (r_count == c_HALF_LAST) begin
                        r_state <= S_DATA;
                        r_count <= '0;
                        r_index <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_DATA: begin
                    // The sample point wins over a coincident resync edge.
                    if (r_count == c_BIT_LAST) begin
                        r_shift[r_index] <= r_rx_s;
                        r_bit_tick       <= 1'b1;
                        r_count          <= '0;
                        if (r_index == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else if (w_resync_edge) begin
                        r_count <= c_RESYNC_LOAD;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_count == c_BIT_LAST) begin
                        r_bit_tick <= 1'b1;
                        r_count    <= '0;
                        r_state    <= S_IDLE;
                        if (r_rx_s) begin
                            r_frame_error <= 1'b1;
                        end else begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end else if (w_resync_edge) begin
                        r_count <= c_RESYNC_LOAD;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.bit_tick    = r_bit_tick;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_optical_bit_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_optical_bit_receiver
// Description : Self-checking bench for optical_bit_receiver. A table of
//               framed bytes (with bit period, stop-bit value and expected
//               outputs), hand-written glitch and mid-frame reset sequences,
//               and randomized frames checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_optical_bit_receiver;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    optical_bit_receiver_if bus ();

    optical_bit_receiver #(
        .BIT_CYCLES (216),
        .HALF_BIT   (108),
        .RESYNC     (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Output event counters collected on the falling edge.
    int n_valid     = 0;
    int n_ferr      = 0;
    int n_tick      = 0;
    int n_both      = 0;
    int n_rst_pulse = 0;

    always @(negedge clock) begin
        if (bus.data_valid)  n_valid++;
        if (bus.frame_error) n_ferr++;
        if (bus.bit_tick)    n_tick++;
        if (bus.data_valid && bus.frame_error) n_both++;
        if (reset && (bus.data_valid || bus.frame_error)) n_rst_pulse++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one frame: start(1), data LSB first, stop bit value, each per clocks.
    task automatic send_frame(input logic [7:0] d, input int per, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b1};
        for (int i = 0; i < 10; i++) begin
            bus.rx_in = f[i];
            repeat (per) @(negedge clock);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         per;
        logic       stop;
        int         gap;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs [6];

    int         b_valid, b_ferr, b_tick;
    logic [7:0] model_dout;
    logic [7:0] rd;
    logic [9:0] fr;
    int         rper, rgap, rhold;
    logic       rstop;

    initial begin
        vecs[0] = '{8'hA5, 216, 1'b0, 20, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 216, 1'b0,  0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 216, 1'b0, 20, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 216, 1'b1, 20, 0, 1, 8'hFF};
        vecs[4] = '{8'h96, 212, 1'b0, 20, 1, 0, 8'h96};
        vecs[5] = '{8'h96, 220, 1'b0, 20, 1, 0, 8'h96};

        bus.rx_in = 1'b0;
        reset     = 1'b1;
        repeat (5) @(negedge clock);
        check("reset_data_out",    int'(bus.data_out),    0);
        check("reset_data_valid",  int'(bus.data_valid),  0);
        check("reset_frame_error", int'(bus.frame_error), 0);
        check("reset_busy",        int'(bus.busy),        0);
        check("reset_bit_tick",    int'(bus.bit_tick),    0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            b_valid = n_valid;
            b_ferr  = n_ferr;
            b_tick  = n_tick;
            send_frame(vecs[i].data, vecs[i].per, vecs[i].stop);
            #1;
            check($sformatf("vec%0d_valid", i), n_valid - b_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i),  n_ferr - b_ferr,   vecs[i].exp_ferr);
            check($sformatf("vec%0d_ticks", i), n_tick - b_tick,   9);
            check($sformatf("vec%0d_dout", i),  int'(bus.data_out), int'(vecs[i].exp_dout));
            check($sformatf("vec%0d_busy", i),  int'(bus.busy),    0);
            if (vecs[i].stop) begin
                // Line left high after the bad stop bit must not restart reception.
                repeat (600) @(negedge clock);
                #1;
                check($sformatf("vec%0d_hold_busy", i), int'(bus.busy), 0);
                check($sformatf("vec%0d_hold_events", i),
                      (n_valid - b_valid) + (n_ferr - b_ferr) + (n_tick - b_tick), 10);
                bus.rx_in = 1'b0;
            end
            repeat (vecs[i].gap) @(negedge clock);
        end

        // 50-clock glitch on the idle line.
        b_valid = n_valid;
        b_ferr  = n_ferr;
        bus.rx_in = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_busy_during", int'(bus.busy), 1);
        repeat (10) @(negedge clock);
        bus.rx_in = 1'b0;
        repeat (200) @(negedge clock);
        #1;
        check("glitch_valid", n_valid - b_valid, 0);
        check("glitch_ferr",  n_ferr - b_ferr,   0);
        check("glitch_busy_after", int'(bus.busy), 0);

        // Reset during data bit 4; the transmitter is cut off at the same time.
        fr = {1'b0, 8'hC3, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bus.rx_in = fr[i];
            repeat (216) @(negedge clock);
        end
        bus.rx_in = fr[5];
        repeat (100) @(negedge clock);
        check("pre_reset_busy", int'(bus.busy), 1);
        b_valid   = n_valid;
        b_ferr    = n_ferr;
        reset     = 1'b1;
        bus.rx_in = 1'b0;
        @(negedge clock);
        check("midreset_busy",        int'(bus.busy),        0);
        check("midreset_data_out",    int'(bus.data_out),    0);
        check("midreset_data_valid",  int'(bus.data_valid),  0);
        check("midreset_frame_error", int'(bus.frame_error), 0);
        check("midreset_bit_tick",    int'(bus.bit_tick),    0);
        reset = 1'b0;
        repeat (400) @(negedge clock);
        #1;
        check("postreset_no_valid", n_valid - b_valid, 0);
        check("postreset_no_ferr",  n_ferr - b_ferr,   0);
        b_valid = n_valid;
        send_frame(8'h5A, 216, 1'b0);
        #1;
        check("postreset_5a_valid", n_valid - b_valid, 1);
        check("postreset_5a_dout",  int'(bus.data_out), 8'h5A);
        repeat (20) @(negedge clock);

        // Randomized frames against a frame-level model: a good stop bit
        // delivers the byte, a bad one flags an error and keeps the old byte.
        model_dout = 8'h5A;
        for (int k = 0; k < 16; k++) begin
            rd    = 8'($urandom);
            rper  = int'($urandom_range(212, 220));
            rstop = ($urandom_range(0, 4) == 0);
            rgap  = int'($urandom_range(2, 60));
            b_valid = n_valid;
            b_ferr  = n_ferr;
            send_frame(rd, rper, rstop);
            #1;
            if (!rstop) model_dout = rd;
            check($sformatf("rnd%0d_valid", k), n_valid - b_valid, rstop ? 0 : 1);
            check($sformatf("rnd%0d_ferr", k),  n_ferr - b_ferr,   rstop ? 1 : 0);
            check($sformatf("rnd%0d_dout", k),  int'(bus.data_out), int'(model_dout));
            if (rstop) begin
                rhold = int'($urandom_range(10, 300));
                repeat (rhold) @(negedge clock);
                bus.rx_in = 1'b0;
            end
            repeat (rgap) @(negedge clock);
        end

        #1;
        check("never_valid_and_ferr", n_both, 0);
        check("no_pulse_in_reset",    n_rst_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
